// File: rtl/pixel_stream_fifo.sv
// Buffered pixel path: DEPTH-entry FIFO with raster annotation of each outgoing pixel,
// frame-completion pulse, and a synchronised, edge-detected display frame index.
module pixel_stream_fifo #(
    parameter int unsigned PIXEL_W = 24,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned H_RES   = 64,
    parameter int unsigned V_RES   = 64
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic                       pixel_valid_i,
    output logic                       pixel_ready_o,
    input  logic [PIXEL_W-1:0]         pixel_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PIXEL_W-1:0]         out_data_o,
    output logic [$clog2(H_RES)-1:0]   out_x_o,
    output logic [$clog2(V_RES)-1:0]   out_y_o,
    output logic                       out_sof_o,
    output logic                       out_eol_o,
    output logic                       frame_done_o,
    output logic [$clog2(DEPTH):0]     level_o,
    input  logic                       frame_idx_i,
    output logic                       frame_idx_o,
    output logic                       frame_toggle_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned XW = $clog2(H_RES);
    localparam int unsigned YW = $clog2(V_RES);

    localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
    localparam logic [XW-1:0] XLast     = XW'(H_RES - 1);
    localparam logic [YW-1:0] YLast     = YW'(V_RES - 1);

    logic [PIXEL_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic               frame_done_q, frame_done_d;
    logic               push, pop, last_pix;

    logic idx_meta_q, idx_sync_q, idx_prev_q, toggle_q;

    assign pixel_ready_o = (level_q != LevelFull);
    assign out_valid_o   = (level_q != '0);
    assign out_data_o    = mem_q[rd_ptr_q];
    assign out_x_o       = x_q;
    assign out_y_o       = y_q;
    assign out_sof_o     = (x_q == '0) && (y_q == '0);
    assign out_eol_o     = (x_q == XLast);
    assign frame_done_o  = frame_done_q;
    assign level_o       = level_q;
    assign frame_idx_o    = idx_sync_q;
    assign frame_toggle_o = toggle_q;

    assign push     = pixel_valid_i && pixel_ready_o;
    assign pop      = out_valid_o && out_ready_i;
    assign last_pix = (x_q == XLast) && (y_q == YLast);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            x_d      = '0;
            y_d      = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            // Raster position tracks the head pixel, so it only moves on pops.
            if (pop) begin
                frame_done_d = last_pix;
                if (x_q == XLast) begin
                    x_d = '0;
                    y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset; entries are only observed once written.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= pixel_data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idx_meta_q <= 1'b0;
            idx_sync_q <= 1'b0;
            idx_prev_q <= 1'b0;
            toggle_q   <= 1'b0;
        end else begin
            idx_meta_q <= frame_idx_i;
            idx_sync_q <= idx_meta_q;
            idx_prev_q <= idx_sync_q;
            toggle_q   <= idx_sync_q ^ idx_prev_q;
        end
    end

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Scoreboard bench for pixel_stream_fifo with a 4x2 raster and a 16-entry FIFO.
module tb_pixel_stream_fifo;

    localparam int unsigned PW = 24;
    localparam int unsigned DP = 16;
    localparam int unsigned HR = 4;
    localparam int unsigned VR = 2;

    logic          clk_i = 1'b0;
    logic          rstn_i, flush_i, pixel_valid_i, pixel_ready_o;
    logic [PW-1:0] pixel_data_i, out_data_o;
    logic          out_valid_o, out_ready_i, out_sof_o, out_eol_o, frame_done_o;
    logic [1:0]    out_x_o;
    logic [0:0]    out_y_o;
    logic [4:0]    level_o;
    logic          frame_idx_i, frame_idx_o, frame_toggle_o;

    pixel_stream_fifo #(.PIXEL_W(PW), .DEPTH(DP), .H_RES(HR), .V_RES(VR)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .pixel_valid_i(pixel_valid_i), .pixel_ready_o(pixel_ready_o),
        .pixel_data_i(pixel_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_x_o(out_x_o), .out_y_o(out_y_o),
        .out_sof_o(out_sof_o), .out_eol_o(out_eol_o), .frame_done_o(frame_done_o),
        .level_o(level_o), .frame_idx_i(frame_idx_i), .frame_idx_o(frame_idx_o),
        .frame_toggle_o(frame_toggle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [PW-1:0] data;
        logic [1:0]    x;
        logic [0:0]    y;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   fd_count = 0;
    int   raster_cnt = 0;
    logic exp_fd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: values at the falling edge are those the next rising edge acts on.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                exp_q.delete();
                raster_cnt = 0;
                exp_fd = 1'b0;
            end else begin
                logic do_push, do_pop;
                exp_t e;
                chk("level", 64'(level_o), 64'(exp_q.size()));
                chk("ready", 64'(pixel_ready_o), 64'(exp_q.size() < DP));
                chk("valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
                chk("frame_done", 64'(frame_done_o), 64'(exp_fd));
                if (frame_done_o) fd_count++;
                do_push = pixel_valid_i && (exp_q.size() < DP);
                do_pop  = out_ready_i && (exp_q.size() != 0);
                exp_fd  = 1'b0;
                if (flush_i) begin
                    exp_q.delete();
                    raster_cnt = 0;
                end else begin
                    if (do_pop) begin
                        e = exp_q.pop_front();
                        chk("data", 64'(out_data_o), 64'(e.data));
                        chk("x", 64'(out_x_o), 64'(e.x));
                        chk("y", 64'(out_y_o), 64'(e.y));
                        chk("sof", 64'(out_sof_o), 64'(e.x == 0 && e.y == 0));
                        chk("eol", 64'(out_eol_o), 64'(e.x == 2'(HR - 1)));
                        exp_fd = (e.x == 2'(HR - 1)) && (e.y == 1'(VR - 1));
                    end
                    if (do_push) begin
                        e.data = pixel_data_i;
                        e.x    = 2'(raster_cnt % HR);
                        e.y    = 1'(raster_cnt / HR);
                        exp_q.push_back(e);
                        raster_cnt = (raster_cnt + 1) % (HR * VR);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic r, input logic f);
        pixel_valid_i = v;
        pixel_data_i  = d;
        out_ready_i   = r;
        flush_i       = f;
    endtask

    initial begin
        int fd_before, pulses;
        rstn_i = 1'b0;
        frame_idx_i = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        step(3);
        chk("rst_ready", 64'(pixel_ready_o), 64'd1);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_toggle", 64'(frame_toggle_o), 64'd0);
        chk("rst_idx", 64'(frame_idx_o), 64'd0);
        chk("rst_fd", 64'(frame_done_o), 64'd0);
        rstn_i = 1'b1;
        step(1);

        // Single pixel, sink stalled: visible one cycle later
        drive(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t1_valid", 64'(out_valid_o), 64'd1);
        chk("t1_data", 64'(out_data_o), 64'hABCDEF);
        chk("t1_sof", 64'(out_sof_o), 64'd1);
        chk("t1_level", 64'(level_o), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b1);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Fill past full: only 0..15 accepted
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, PW'(i), 1'b0, 1'b0);
            step(1);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t2_ready_full", 64'(pixel_ready_o), 64'd0);
        chk("t2_level_full", 64'(level_o), 64'd16);
        drive(1'b0, '0, 1'b1, 1'b0);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t2_ready_again", 64'(pixel_ready_o), 64'd1);
        chk("t2_level_15", 64'(level_o), 64'd15);
        drive(1'b0, '0, 1'b1, 1'b0);
        step(15);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t2_empty", 64'(level_o), 64'd0);

        // Steady state at level 8 with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, PW'(100 + i), 1'b0, 1'b0);
            step(1);
        end
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, PW'(200 + i), 1'b1, 1'b0);
            step(1);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t3_level8", 64'(level_o), 64'd8);
        drive(1'b0, '0, 1'b1, 1'b0);
        step(8);
        drive(1'b0, '0, 1'b0, 1'b1);
        step(1);

        // One 4x2 frame streamed back to back
        fd_before = fd_count;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, PW'(24'h300 + i), 1'b1, 1'b0);
            step(1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step(3);
        drive(1'b1, 24'h3FF, 1'b0, 1'b0);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t4_fd_once", 64'(fd_count - fd_before), 64'd1);
        chk("t4_x0", 64'(out_x_o), 64'd0);
        chk("t4_y0", 64'(out_y_o), 64'd0);
        chk("t4_sof8", 64'(out_sof_o), 64'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        step(1);

        // Flush mid-frame at x=2 y=1 with level 5
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, PW'(24'h400 + i), 1'b0, 1'b0);
            step(1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step(6);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t5_x2", 64'(out_x_o), 64'd2);
        chk("t5_y1", 64'(out_y_o), 64'd1);
        chk("t5_level5", 64'(level_o), 64'd5);
        drive(1'b1, 24'h4FF, 1'b1, 1'b1);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t5_level0", 64'(level_o), 64'd0);
        chk("t5_valid0", 64'(out_valid_o), 64'd0);
        chk("t5_xy0", 64'({out_x_o, out_y_o}), 64'd0);
        chk("t5_no_fd", 64'(frame_done_o), 64'd0);
        step(2);

        // Frame index synchroniser and edge pulse, both directions
        for (int dir = 0; dir < 2; dir++) begin
            frame_idx_i = (dir == 0);
            pulses = 0;
            for (int c = 1; c <= 8; c++) begin
                step(1);
                if (frame_toggle_o) pulses++;
                if (c == 1) chk("idx_edge1", 64'(frame_idx_o), 64'(dir != 0));
                if (c == 2) chk("idx_edge2", 64'(frame_idx_o), 64'(dir == 0));
                if (c == 3) chk("toggle_edge3", 64'(frame_toggle_o), 64'd1);
            end
            chk("toggle_pulses", 64'(pulses), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_stream_fifo.md
# pixel_stream_fifo

Parametrised buffered pixel path between the SoC pixel source and the display sink, generalising the single-register display interface. It decouples source and sink with a DEPTH-entry FIFO and annotates every outgoing pixel with raster coordinates and start-of-frame and end-of-line markers. It also flags frame completion, and synchronises and edge-detects the display's frame index for the SoC. It sits between `soc` pixel outputs and the display sink within `dut`.

## Interface
- `PIXEL_W`, default 24: pixel data width.
- `DEPTH`, default 16: FIFO entries. Must be a power of two, ≥2.
- `H_RES`, default 64: pixels per line, ≥2.
- `V_RES`, default 64: lines per frame, ≥2.
- `clk_i` in 1: single clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: synchronous flush of FIFO and raster counters.
- `pixel_valid_i` in 1: source pixel valid.
- `pixel_ready_o` out 1: block can accept a pixel.
- `pixel_data_i` in PIXEL_W: source pixel.
- `out_valid_o` out 1: head pixel valid toward sink.
- `out_ready_i` in 1: sink accepts.
- `out_data_o` out PIXEL_W: head pixel.
- `out_x_o` out $clog2(H_RES): column of head pixel.
- `out_y_o` out $clog2(V_RES): line of head pixel.
- `out_sof_o` out 1: head pixel is (0,0).
- `out_eol_o` out 1: head pixel is last in line.
- `frame_done_o` out 1: one-cycle pulse after the last pixel of a frame is accepted.
- `level_o` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `frame_idx_i` in 1: display frame index, asynchronous to pixel flow.
- `frame_idx_o` out 1: synchronised frame index.
- `frame_toggle_o` out 1: one-cycle pulse on each change of `frame_idx_o`.

## Operation
- Push occurs when `pixel_valid_i && pixel_ready_o`. Pop occurs when `out_valid_o && out_ready_i`.
- `pixel_ready_o` = (`level_o` < DEPTH). It depends on registered state only, with no full-pop bypass.
- `out_valid_o` = (`level_o` != 0). `out_data_o` is the FIFO head entry, read from storage indexed by a registered read pointer.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally mod DEPTH.
- Level update per cycle:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, legal at any level 1..DEPTH−1
  - push at level 0 is never popped in the same cycle.
- Raster counters (x, y) advance on every pop only:
  - x increments.
  - At x = H_RES−1, x wraps to 0 and y increments.
  - At y = V_RES−1 with x = H_RES−1, both wrap to 0 and `frame_done_o` pulses on the next cycle.
- `out_sof_o` = (x==0 && y==0). `out_eol_o` = (x==H_RES−1). Both are combinational from the counters and are meaningful only while `out_valid_o` is high.
- `flush_i` has priority over push and pop in the same cycle:
  - pointers, level, x and y go to 0 next cycle
  - `frame_done_o` is suppressed
  - data in flight in that cycle is discarded.
- Frame index path:
  - Two-flop synchroniser produces `frame_idx_o`.
  - A third flop holds the previous `frame_idx_o`.
  - `frame_toggle_o` = XOR of `frame_idx_o` and that previous value, registered.

## Timing
- Reset values:
  - pointers, level, x, y = 0
  - `pixel_ready_o` = 1, `out_valid_o` = 0
  - `frame_done_o` = 0, `frame_toggle_o` = 0
  - `frame_idx_o` = 0, all synchroniser flops = 0
  - `out_data_o` is don't-care while `out_valid_o` = 0.
- Pixel pushed at edge N is visible with `out_valid_o` = 1 after edge N (first possible pop at edge N+1). Latency is 1 cycle.
- `pixel_ready_o` deasserts the cycle after the push that reaches level DEPTH. It reasserts the cycle after the pop from level DEPTH.
- `frame_done_o` is high for exactly the one cycle after the final-pixel pop edge.
- Change on `frame_idx_i` reaches `frame_idx_o` after 2 edges. `frame_toggle_o` is high during the 3rd and 4th cycle window for exactly one cycle.
- Reset asserted mid-frame clears all state immediately (asynchronously). Pending FIFO contents are lost.

## Test plan
- Reset, then push 1 pixel (0xABCDEF) with `out_ready_i` = 0: next cycle `out_valid_o` = 1, `out_data_o` = 0xABCDEF, `out_sof_o` = 1, `level_o` = 1.
- `out_ready_i` = 0, push DEPTH=16 pixels 0..15: `pixel_ready_o` low after the 16th, `level_o` = 16. Further valid is ignored. A single pop reasserts ready next cycle. Drained order is 0..15.
- Continuous push and pop at level 8 for 100 cycles: `level_o` stays 8, data order is preserved, pointers wrap without loss.
- H_RES=4, V_RES=2, stream 8 pixels:
  - `out_eol_o` on x=3 at pixel 3 and pixel 7
  - `out_sof_o` on pixels 0 and 8
  - `frame_done_o` pulses once, the cycle after pixel 7's pop
  - x and y return to 0.
- Mid-frame (x=2, y=1, level 5): assert `flush_i` together with a push and a pop. Next cycle `level_o` = 0, `out_valid_o` = 0, x = y = 0, no `frame_done_o`.
- Toggle `frame_idx_i` 0→1: `frame_idx_o` = 1 two edges later, `frame_toggle_o` is a single 1-cycle pulse. Toggle 1→0 gives a second pulse.
